ether_rx_byte_buffer: RTL and testbench
=======================================

# ether_rx_byte_buffer

Receive-side counterpart of the Ethernet transmit byte buffer. It takes the RMII receive dibit stream, strips preamble and SFD, and reassembles LSB-first dibits into bytes. Each byte goes into an internal FIFO with an end-of-frame marker. Downstream packet logic reads bytes through a valid/ready handshake.

## Interface
- DEPTH, 64: FIFO depth in bytes. Must be a power of 2 and at least 4.
- clk  in  1  system clock, one dibit per cycle when axiiv=1.
- rst  in  1  asynchronous, active-low reset.
- axiiv  in  1  receive dibit valid (carrier/data valid).
- axiid  in  2  receive dibit, LSB-first within each byte.
- axiov  out  1  output byte valid (FIFO not empty).
- axiod  out  8  output byte (head of FIFO).
- axio_last  out  1  head byte is the last byte of its frame.
- axio_ready  in  1  consumer accepts the head byte when axiov=1.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.

## Operation
**States**
- IDLE
  - axiiv=1 with axiid=01 -> PREAMBLE, pre_cnt=1.
  - axiiv=1 with any other dibit -> DROP.
- PREAMBLE
  - axiid=01: pre_cnt++, saturating at 31.
  - axiid=11 with pre_cnt>=3 -> DATA. This is the SFD, 0xD5.
  - axiid=11 with pre_cnt<3, or axiid=00/10 -> DROP.
  - axiiv=0 -> IDLE.
- DROP: ignore input until axiiv=0, then -> IDLE. Nothing is written.
- DATA
  - Shift dibits into the assembly register: dibit k of a byte lands in bits [2k+1:2k]. A 2-bit phase counter tracks k.
  - When a byte completes (phase 3):
    - if the staging register is valid, write it to the FIFO with last=0;
    - load the new byte into staging and set it valid.
  - axiiv=0 -> IDLE:
    - if staging is valid, write it with last=1 and clear staging;
    - discard any partial byte (phase!=0);
    - reset phase to 0.
- A frame with zero complete bytes writes nothing.

**FIFO**
- DEPTH x 9 bits: {last, byte}. Read and write pointers are log2(DEPTH)+1 bits wide so full and empty can be distinguished.
- The read side is first-word-fall-through:
  - axiov = not empty;
  - axiod and axio_last come from mem[rd_ptr];
  - a pop happens when axiov & axio_ready.
- A write attempted while the FIFO is full is dropped and sets overflow. Full is evaluated on the current-cycle state, before that cycle's pop, so a pop and a write in the same full cycle still drop the write.
- When an overflow drops the frame's last byte, that frame has no last marker. The consumer treats overflow=1 as "stream corrupt".
- A pop and a write in the same non-full cycle are both performed; the count is unchanged.
- overflow is cleared only by reset.

**Reset** (rst=0, asynchronous): state=IDLE, pointers=0, staging invalid, phase=0, pre_cnt=0, overflow=0. Resulting outputs:
- axiov=0;
- axiod=whatever mem[0] holds (don't-care);
- axio_last=don't-care.

A reset mid-frame abandons the frame. After reset is released, the block waits for a fresh preamble.

## Timing
- All state updates on the rising clk edge.
- Byte N (not last) is written on the edge that samples the 4th dibit of byte N+1. The last byte is written on the edge that samples axiiv=0.
- axiov rises in the cycle after the write edge. Minimum latency from the last data dibit to axiov=1 is 2 cycles.
- At most one FIFO write per cycle.
- Minimum inter-frame gap is 1 cycle of axiiv=0.
- The consumer may hold axio_ready low indefinitely. axiod and axio_last stay stable while axiov=1 and axio_ready=0.

## Test plan
- **Reset:** hold rst=0 for 2 cycles mid-stream.
  - Required: axiov=0 and overflow=0 immediately (asynchronously).
  - Required: no output bytes until a new frame arrives.
- **Nominal frame:** 28 dibits of 01, then 01,01,01,11, then bytes 0xD2 and 0x3C (dibits 10,00,01,11 / 00,11,11,00), then axiiv=0; axio_ready=1.
  - Required: outputs D2/last=0, then 3C/last=1, then axiov=0.
- **Bad preamble:** 01,01,10,01,11, followed by valid-looking data while axiiv stays 1.
  - Required: axiov stays 0.
  - Required: the next correct frame after an axiiv=0 gap is received normally.
- **Partial byte:** valid frame with bytes 0xAA, 0x55, then 2 extra dibits, then axiiv=0.
  - Required: outputs AA/0, then 55/1; the partial byte is discarded.
- **Overflow:** DEPTH=4, axio_ready=0, valid frame of 6 bytes 0x01..0x06.
  - Required: overflow=1.
  - Required: FIFO holds 01..04, all with last=0.
  - Required: raising axio_ready drains exactly 4 bytes.
- **Backpressure:** two back-to-back frames of 3 bytes each with a 1-cycle gap; axio_ready toggles 1,0,1,0.
  - Required: all 6 bytes arrive in order, last set on the 3rd and 6th.
  - Required: no duplicates or drops; overflow=0.

Source files
------------

// File: rtl/ether_rx_byte_buffer.sv
// RMII receive path: strips preamble/SFD, packs LSB-first dibits into bytes and
// queues them with an end-of-frame flag in a first-word-fall-through FIFO.
module ether_rx_byte_buffer #(
   parameter int DEPTH = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       axiiv,
   input  logic [1:0] axiid,
   output logic       axiov,
   output logic [7:0] axiod,
   output logic       axio_last,
   input  logic       axio_ready,
   output logic       overflow,
   output logic [1:0] dbg_state
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DROP, S_DATA} state_t;

   state_t      state_q, state_d;
   logic [4:0]  pre_cnt_q, pre_cnt_d;
   logic [1:0]  phase_q, phase_d;
   logic [5:0]  asm_q, asm_d;
   logic [7:0]  stage_q, stage_d;
   logic        stage_vld_q, stage_vld_d;
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        overflow_q, overflow_d;
   logic [8:0]  mem [DEPTH];

   logic        wr_en;
   logic [8:0]  wr_data;
   logic        full;
   logic        empty;
   logic        pop;

   // Valid/ready: a byte is consumed on a rising edge where axiov and axio_ready are both 1;
   // the head byte and its last flag hold steady until that edge.
   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign axiov     = !empty;
   assign pop       = axiov && axio_ready;
   assign axiod     = mem[rd_ptr_q[AW-1:0]][7:0];
   assign axio_last = mem[rd_ptr_q[AW-1:0]][8];
   assign overflow  = overflow_q;
   assign dbg_state = state_q;

   always_comb begin
      state_d     = state_q;
      pre_cnt_d   = pre_cnt_q;
      phase_d     = phase_q;
      asm_d       = asm_q;
      stage_d     = stage_q;
      stage_vld_d = stage_vld_q;
      wr_en       = 1'b0;
      wr_data     = 9'd0;
      case (state_q)
         S_IDLE: begin
            if (axiiv) begin
               if (axiid == 2'b01) begin
                  state_d   = S_PREAMBLE;
                  pre_cnt_d = 5'd1;
               end else begin
                  state_d = S_DROP;
               end
            end
         end
         S_PREAMBLE: begin
            if (!axiiv) begin
               state_d = S_IDLE;
            end else if (axiid == 2'b01) begin
               if (pre_cnt_q != 5'd31) pre_cnt_d = pre_cnt_q + 5'd1;
            end else if (axiid == 2'b11 && pre_cnt_q >= 5'd3) begin
               state_d = S_DATA;
               phase_d = 2'd0;
            end else begin
               state_d = S_DROP;
            end
         end
         S_DROP: begin
            if (!axiiv) state_d = S_IDLE;
         end
         default: begin
            if (axiiv) begin
               phase_d = phase_q + 2'd1;
               case (phase_q)
                  2'd0: asm_d[1:0] = axiid;
                  2'd1: asm_d[3:2] = axiid;
                  2'd2: asm_d[5:4] = axiid;
                  default: begin
                     // Hold one byte back so the end of frame can tag it as last.
                     if (stage_vld_q) begin
                        wr_en   = 1'b1;
                        wr_data = {1'b0, stage_q};
                     end
                     stage_d     = {axiid, asm_q};
                     stage_vld_d = 1'b1;
                  end
               endcase
            end else begin
               if (stage_vld_q) begin
                  wr_en   = 1'b1;
                  wr_data = {1'b1, stage_q};
               end
               stage_vld_d = 1'b0;
               phase_d     = 2'd0;
               state_d     = S_IDLE;
            end
         end
      endcase
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      overflow_d = overflow_q;
      if (wr_en) begin
         if (full) overflow_d = 1'b1;
         else      wr_ptr_d   = wr_ptr_q + (AW+1)'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         pre_cnt_q   <= 5'd0;
         phase_q     <= 2'd0;
         asm_q       <= 6'd0;
         stage_q     <= 8'd0;
         stage_vld_q <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pre_cnt_q   <= pre_cnt_d;
         phase_q     <= phase_d;
         asm_q       <= asm_d;
         stage_q     <= stage_d;
         stage_vld_q <= stage_vld_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         overflow_q  <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && !full) mem[wr_ptr_q[AW-1:0]] <= wr_data;
   end

endmodule

// File: tb/tb_ether_rx_byte_buffer.sv
// Directed bench for ether_rx_byte_buffer: frames are driven dibit by dibit and the
// popped {last, byte} stream is compared against hand-written expectations.
module tb_ether_rx_byte_buffer;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       axiiv = 1'b0;
   logic [1:0] axiid = 2'b00;
   logic       axio_ready = 1'b0;
   logic       axiov;
   logic [7:0] axiod;
   logic       axio_last;
   logic       overflow;
   logic [1:0] dbg_state;

   int   n_cmp = 0;
   int   n_bad = 0;
   logic bp_en = 1'b0;

   logic [8:0] exp_q[$];
   logic [8:0] got_q[$];

   ether_rx_byte_buffer #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .axiiv      (axiiv),
      .axiid      (axiid),
      .axiov      (axiov),
      .axiod      (axiod),
      .axio_last  (axio_last),
      .axio_ready (axio_ready),
      .overflow   (overflow),
      .dbg_state  (dbg_state)
   );

   always #5 clk = ~clk;

   // Inputs change 1 ns after the rising edge, so at the falling edge the
   // handshake that the next rising edge will perform is already visible.
   always @(negedge clk) begin
      if (rst && axiov && axio_ready) got_q.push_back({axio_last, axiod});
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (bp_en) axio_ready = ~axio_ready;
   endtask

   task automatic send_dibit(input logic [1:0] d);
      axiiv = 1'b1;
      axiid = d;
      tick();
   endtask

   task automatic idle(input int n);
      axiiv = 1'b0;
      axiid = 2'b00;
      repeat (n) tick();
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int k = 0; k < 4; k++) send_dibit(b[2*k +: 2]);
   endtask

   task automatic send_preamble(input int n01);
      repeat (n01) send_dibit(2'b01);
      send_dibit(2'b11);
   endtask

   task automatic expect_byte(input logic [7:0] b, input logic last);
      exp_q.push_back({last, b});
   endtask

   task automatic compare_stream(input string tag);
      int n;
      check_eq({tag, ".count"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check_eq($sformatf("%s.byte%0d", tag, i), got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      // power-on reset
      #1;
      check_eq("reset.axiov", axiov, 0);
      check_eq("reset.overflow", overflow, 0);
      check_eq("reset.state", dbg_state, 0);
      idle(2);
      rst = 1'b1;
      idle(2);

      // nominal frame
      axio_ready = 1'b1;
      send_preamble(31);
      send_byte(8'hD2);
      send_byte(8'h3C);
      idle(6);
      expect_byte(8'hD2, 1'b0);
      expect_byte(8'h3C, 1'b1);
      compare_stream("nominal");
      check_eq("nominal.axiov_after", axiov, 0);

      // bad preamble, data keeps coming while axiiv stays high
      send_dibit(2'b01);
      send_dibit(2'b01);
      send_dibit(2'b10);
      send_dibit(2'b01);
      send_dibit(2'b11);
      send_byte(8'hD2);
      send_byte(8'h3C);
      idle(6);
      check_eq("badpre.axiov", axiov, 0);
      compare_stream("badpre");
      send_preamble(31);
      send_byte(8'h77);
      idle(6);
      expect_byte(8'h77, 1'b1);
      compare_stream("badpre.recover");

      // SFD after only two preamble dibits is rejected; after three it is accepted
      send_preamble(2);
      send_byte(8'h5A);
      idle(6);
      compare_stream("short_pre2");
      send_preamble(3);
      send_byte(8'h5A);
      send_byte(8'hA5);
      idle(6);
      expect_byte(8'h5A, 1'b0);
      expect_byte(8'hA5, 1'b1);
      compare_stream("short_pre3");

      // partial trailing byte
      send_preamble(31);
      send_byte(8'hAA);
      send_byte(8'h55);
      send_dibit(2'b01);
      send_dibit(2'b10);
      idle(6);
      expect_byte(8'hAA, 1'b0);
      expect_byte(8'h55, 1'b1);
      compare_stream("partial");

      // frame with no complete byte
      send_preamble(31);
      send_dibit(2'b11);
      send_dibit(2'b10);
      idle(6);
      compare_stream("zero_byte");
      check_eq("zero_byte.axiov", axiov, 0);
      check_eq("pre_ovf.overflow", overflow, 0);

      // overflow with the consumer stalled
      axio_ready = 1'b0;
      send_preamble(31);
      for (int i = 1; i <= 6; i++) send_byte(8'(i));
      idle(4);
      check_eq("ovf.overflow", overflow, 1);
      check_eq("ovf.axiov", axiov, 1);
      check_eq("ovf.head", axiod, 8'h01);
      check_eq("ovf.head_last", axio_last, 0);
      idle(5);
      check_eq("ovf.head_stable", axiod, 8'h01);
      axio_ready = 1'b1;
      idle(8);
      for (int i = 1; i <= 4; i++) expect_byte(8'(i), 1'b0);
      compare_stream("ovf.drain");
      check_eq("ovf.axiov_after", axiov, 0);
      check_eq("ovf.sticky", overflow, 1);

      // asynchronous reset in the middle of a frame with bytes queued
      axio_ready = 1'b0;
      send_preamble(31);
      send_byte(8'h11);
      send_byte(8'h22);
      idle(3);
      check_eq("rst.queued", axiov, 1);
      send_preamble(31);
      send_byte(8'h33);
      send_dibit(2'b10);
      send_dibit(2'b01);
      #2;
      rst = 1'b0;
      #1;
      check_eq("rst.async_axiov", axiov, 0);
      check_eq("rst.async_overflow", overflow, 0);
      @(posedge clk);
      #1;
      repeat (2) tick();
      rst = 1'b1;
      send_byte(8'hFF);
      send_byte(8'hFF);
      idle(2);
      axio_ready = 1'b1;
      idle(6);
      compare_stream("rst.after");
      check_eq("rst.axiov_after", axiov, 0);

      // back-to-back frames with toggling ready
      axio_ready = 1'b1;
      bp_en = 1'b1;
      send_preamble(31);
      send_byte(8'hA1);
      send_byte(8'hA2);
      send_byte(8'hA3);
      idle(1);
      send_preamble(31);
      send_byte(8'hB1);
      send_byte(8'hB2);
      send_byte(8'hB3);
      idle(20);
      bp_en = 1'b0;
      expect_byte(8'hA1, 1'b0);
      expect_byte(8'hA2, 1'b0);
      expect_byte(8'hA3, 1'b1);
      expect_byte(8'hB1, 1'b0);
      expect_byte(8'hB2, 1'b0);
      expect_byte(8'hB3, 1'b1);
      compare_stream("bp");
      check_eq("bp.overflow", overflow, 0);
      check_eq("bp.axiov_after", axiov, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
